// File: rtl/text_frame_scheduler.sv
// Streams one OLED frame from the text engine's pixel port to the screen driver through a credit-counted FIFO.
// Start latency 3 clk, then 1 byte/clk; byte_ready low stalls issue once FIFO plus in-flight reads fill the FIFO.

module tfs_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module text_frame_scheduler #(
  parameter int          FRAME_BYTES = 1024,
  parameter int          ADDR_W      = 10,
  parameter logic [15:0] GAP_CYCLES  = 16'd1000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              auto_refresh,
  input  logic              abort,
  output logic [ADDR_W-1:0] pixel_address,
  input  logic [7:0]        pixel_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAP} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] issue_addr;
  logic              iq1, iq2, lst1, lst2;
  logic [15:0]       gap_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic [8:0]        head;
  logic              issue, last_issue, pop, last_xfer, abort_now, gap_done;

  assign abort_now  = abort && (state_q != IDLE);
  // Bytes already owned by the FIFO plus reads still in flight; issue only while this leaves a free slot.
  assign occupancy  = {1'b0, fifo_count} + (CW+1)'(iq1) + (CW+1)'(iq2);
  assign last_issue = issue && (issue_addr == ADDR_W'(FRAME_BYTES - 1));
  assign pop        = byte_valid && byte_ready;
  assign last_xfer  = pop && byte_last;
  assign gap_done   = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES};

  assign byte_valid = (fifo_count != '0);
  assign byte_data  = head[7:0];
  assign byte_last  = byte_valid && head[8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start || auto_refresh) state_d = RUN;
        RUN:     if (last_issue) state_d = DRAIN;
        DRAIN:   if (last_xfer) state_d = auto_refresh ? GAP : IDLE;
        GAP:     if (gap_done) state_d = auto_refresh ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q != IDLE);
    issue = (state_q == RUN) && !abort_now && (occupancy < (CW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_address <= '0;
      issue_addr    <= '0;
      iq1           <= 1'b0;
      iq2           <= 1'b0;
      lst1          <= 1'b0;
      lst2          <= 1'b0;
      gap_cnt       <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
    end else begin
      if (abort_now) begin
        iq1  <= 1'b0;
        iq2  <= 1'b0;
        lst1 <= 1'b0;
        lst2 <= 1'b0;
      end else begin
        iq1  <= issue;
        iq2  <= iq1;
        lst1 <= last_issue;
        lst2 <= lst1;
      end
      if (issue) pixel_address <= issue_addr;
      if (abort_now || last_issue) issue_addr <= '0;
      else if (issue)              issue_addr <= issue_addr + ADDR_W'(1);
      gap_cnt    <= (state_q == GAP) ? gap_cnt + 16'd1 : 16'd0;
      frame_done <= last_xfer && !abort_now;
      if (last_xfer && !abort_now) frame_count <= frame_count + 16'd1;
    end
  end

  tfs_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (abort_now),
    .push     (iq2),
    .push_dat ({lst2, pixel_data}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_text_frame_scheduler.sv
// Directed bench for text_frame_scheduler: engine model returns address[7:0] one edge after the address is seen.
module tb_text_frame_scheduler;
  localparam int FB = 1024;

  logic        clk = 1'b0;
  logic        resetn, start, auto_refresh, abort, byte_ready;
  logic [9:0]  pixel_address;
  logic [7:0]  pixel_data, byte_data;
  logic        byte_valid, byte_last, busy, frame_done;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  int exp_idx, cyc_n, last_cyc, done_cyc, done_cnt, max_fifo;
  int s0, d1, d2, d3, n, fc0;
  bit rmode;

  text_frame_scheduler #(.GAP_CYCLES(16'd10)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .auto_refresh  (auto_refresh),
    .abort         (abort),
    .pixel_address (pixel_address),
    .pixel_data    (pixel_data),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .byte_last     (byte_last),
    .byte_ready    (byte_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard any transfer at the edge, check stall hold, feed the engine model.
  task automatic cyc();
    logic       xfer, stall, lst, ab;
    logic [7:0] dat;
    logic [9:0] pa;
    if (rmode) byte_ready = ($urandom_range(0, 9) < 3);
    xfer  = byte_valid & byte_ready;
    stall = byte_valid & ~byte_ready;
    dat   = byte_data;
    lst   = byte_last;
    pa    = pixel_address;
    ab    = abort;
    @(posedge clk);
    #1;
    cyc_n++;
    pixel_data = pa[7:0];
    if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
    if (xfer) begin
      chk("byte_data", dat, exp_idx[7:0]);
      chk("byte_last", lst, exp_idx == FB - 1);
      if (lst) last_cyc = cyc_n;
      exp_idx++;
    end
    if (stall && !ab && resetn)
      chk("stall_hold", {byte_valid, byte_last, byte_data}, {1'b1, lst, dat});
    if (frame_done) begin
      chk("frame_len", exp_idx, FB);
      chk("done_after_last", cyc_n, last_cyc);
      done_cyc = cyc_n;
      done_cnt++;
      exp_idx = 0;
    end
  endtask

  task automatic wait_done(input int bound);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == n0; i++) cyc();
    chk("done_timeout", done_cnt, n0 + 1);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; auto_refresh = 1'b0; abort = 1'b0;
    byte_ready = 1'b0; pixel_data = 8'd0; rmode = 1'b0;
    exp_idx = 0; cyc_n = 0; last_cyc = -1; done_cyc = 0; done_cnt = 0; max_fifo = 0;
    #3;
    chk("rst_valid", byte_valid, 0);
    chk("rst_last", byte_last, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_addr", pixel_address, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1: single frame at full rate
    byte_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0; s0 = cyc_n;
    chk("t1_busy", busy, 1);
    chk("t1_valid_e0", byte_valid, 0);
    cyc();
    chk("t1_addr0", pixel_address, 0);
    chk("t1_valid_e1", byte_valid, 0);
    cyc();
    chk("t1_valid_e2", byte_valid, 0);
    cyc();
    chk("t1_first_valid", byte_valid, 1);
    chk("t1_first_data", byte_data, 0);
    wait_done(1100);
    chk("t1_latency", done_cyc - s0, 1027);
    chk("t1_count", frame_count, 1);
    chk("t1_idle", busy, 0);
    cyc();
    chk("t1_done_pulse", frame_done, 0);

    // 2: random 30% ready duty
    rmode = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    wait_done(8000);
    rmode = 1'b0; byte_ready = 1'b1;
    chk("t2_max_fifo", max_fifo <= 4, 1);
    chk("t2_count", frame_count, 2);

    // 3: ready held low, then released
    byte_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (50) cyc();
    chk("t3_addr_hold", pixel_address, 3);
    chk("t3_fifo_count", dut.fifo_count, 4);
    chk("t3_head", byte_data, 0);
    chk("t3_valid", byte_valid, 1);
    chk("t3_busy", busy, 1);
    byte_ready = 1'b1;
    repeat (20) cyc();
    chk("t3_no_gap", exp_idx, 20);
    wait_done(1100);
    chk("t3_count", frame_count, 3);

    // 4: auto refresh, gap of 10
    auto_refresh = 1'b1;
    wait_done(1100); d1 = done_cyc;
    chk("t4_count1", frame_count, 4);
    wait_done(1100); d2 = done_cyc;
    chk("t4_count2", frame_count, 5);
    wait_done(1100); d3 = done_cyc;
    chk("t4_count3", frame_count, 6);
    chk("t4_space12", d2 - d1, 1037);
    chk("t4_space23", d3 - d2, 1037);
    chk("t4_gap_busy", busy, 1);
    auto_refresh = 1'b0;
    repeat (15) cyc();
    chk("t4_idle", busy, 0);
    chk("t4_no_valid", byte_valid, 0);
    chk("t4_count_hold", frame_count, 6);

    // 5: abort mid-frame, with a simultaneous start that must be ignored
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 1100 && exp_idx < 500; i++) cyc();
    chk("t5_reach", exp_idx, 500);
    fc0 = frame_count;
    abort = 1'b1; start = 1'b1; cyc(); abort = 1'b0; start = 1'b0;
    chk("t5_valid", byte_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", frame_done, 0);
    chk("t5_count", frame_count, fc0);
    n = done_cnt;
    repeat (10) cyc();
    chk("t5_no_done", done_cnt, n);
    chk("t5_stay_idle", busy, 0);
    exp_idx = 0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("t5_restart_addr", pixel_address, 0);
    wait_done(1100);
    chk("t5_count_after", frame_count, fc0 + 1);

    // 6: asynchronous reset mid-frame
    start = 1'b1; cyc(); start = 1'b0;
    repeat (300) cyc();
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", byte_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_addr", pixel_address, 0);
    chk("t6_count", frame_count, 0);
    chk("t6_last", byte_last, 0);
    chk("t6_data", byte_data, 0);
    chk("t6_done", frame_done, 0);
    cyc();
    chk("t6_busy_held", busy, 0);
    resetn = 1'b1;
    exp_idx = 0;
    start = 1'b1; cyc(); start = 1'b0;
    wait_done(1100);
    chk("t6_count_after", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
